mem_stage_sram: RTL and testbench

Memory stage of the ARM pipeline. It sits directly downstream of the execute stage and consumes that stage's alu_result (byte address), val_rm (store data), mem_r_en and mem_w_en. LDR/STR requests become a two-half-word access sequence on an external 16-bit SRAM. While an access is in flight, ready is held low so the hazard/freeze logic stalls every upstream stage.

---
 rtl/mem_stage_sram_pkg.sv | 22 ++
 rtl/mem_stage_sram.sv | 159 +++++++++++++++
 tb/tb_mem_stage_sram.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_sram_pkg
//  Purpose  : Shared state encoding and address-map constant for the memory
//             stage, its hazard unit and its testbench.
//  Revision : 1.0  initial release
// ============================================================================
package mem_stage_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int BASE_ADDR_DEFAULT = 1024;

endpackage
`default_nettype wire

// File: rtl/mem_stage_sram.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_sram
//  Purpose  : ARM pipeline memory stage; turns LDR/STR into two half-word
//             accesses on a 16-bit SRAM and freezes the pipeline meanwhile.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int ADDR_W        = 18,
    parameter int BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       val_rm,
    output logic [31:0]       mem_result,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam int              WORD_W   = ADDR_W - 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        lo_q, lo_d;
    logic [31:0]        mem_result_q, mem_result_d;

    logic               req;
    logic               cnt_last;
    logic [WORD_W-1:0]  word_in;

    assign req      = mem_r_en | mem_w_en;
    assign cnt_last = (cnt_q == CNT_LAST);
    // Out-of-range addresses simply wrap within the SRAM word space.
    assign word_in  = WORD_W'((alu_result - 32'(BASE_ADDR)) >> 2);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        mem_result_d = mem_result_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    word_d  = word_in;
                    wdata_d = val_rm;
                    state_d = mem_w_en ? ST_WR_LO : ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                if (cnt_last) begin
                    lo_d    = sram_dq_in;
                    cnt_d   = '0;
                    state_d = ST_RD_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_HI: begin
                if (cnt_last) begin
                    mem_result_d = {sram_dq_in, lo_q};
                    cnt_d        = '0;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_LO: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_WR_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_HI: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state_q)
            ST_RD_LO: begin
                sram_addr = {word_q, 1'b0};
                sram_oe_n = 1'b0;
            end
            ST_RD_HI: begin
                sram_addr = {word_q, 1'b1};
                sram_oe_n = 1'b0;
            end
            ST_WR_LO: begin
                sram_addr   = {word_q, 1'b0};
                sram_dq_out = wdata_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            ST_WR_HI: begin
                sram_addr   = {word_q, 1'b1};
                sram_dq_out = wdata_q[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            default: ;
        endcase
    end

    // A fresh request is never acknowledged in the cycle it first appears.
    assign ready      = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
    assign mem_result = mem_result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            mem_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            mem_result_q <= mem_result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_sram
//  Purpose  : Scoreboard bench for mem_stage_sram at ACCESS_CYCLES=2 and =1,
//             each instance backed by a behavioural 16-bit SRAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_sram;

    localparam int ADDR_W = 18;
    localparam int BASE   = mem_stage_sram_pkg::BASE_ADDR_DEFAULT;

    typedef struct {
        int                lat;
        logic [31:0]       res;
        bit                chk_mem;
        logic [ADDR_W-1:0] a0;
        logic [15:0]       d0;
        logic [15:0]       d1;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              r_en  [2];
    logic              w_en  [2];
    logic [31:0]       alu   [2];
    logic [31:0]       vrm   [2];
    logic [31:0]       mres  [2];
    logic              rdy   [2];
    logic [ADDR_W-1:0] saddr [2];
    logic [15:0]       sdo   [2];
    logic [15:0]       sdi   [2];
    logic              soe   [2];
    logic              swe_n [2];
    logic              soe_n [2];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int AC = (g == 0) ? 2 : 1;

        logic [15:0]       mem [0:(1<<ADDR_W)-1];
        logic [ADDR_W-1:0] track    = '0;
        logic              track_ok = 1'b0;
        int                age      = 0;
        int                low_cnt  = 0;

        mem_stage_sram #(
            .ADDR_W        (ADDR_W),
            .BASE_ADDR     (BASE),
            .ACCESS_CYCLES (AC)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .mem_r_en    (r_en[g]),
            .mem_w_en    (w_en[g]),
            .alu_result  (alu[g]),
            .val_rm      (vrm[g]),
            .mem_result  (mres[g]),
            .ready       (rdy[g]),
            .sram_addr   (saddr[g]),
            .sram_dq_out (sdo[g]),
            .sram_dq_in  (sdi[g]),
            .sram_dq_oe  (soe[g]),
            .sram_we_n   (swe_n[g]),
            .sram_oe_n   (soe_n[g])
        );

        // Read data is only valid once the address has been held AC cycles.
        always @(posedge clk) begin
            if (!swe_n[g]) mem[saddr[g]] <= sdo[g];
            if (!soe_n[g]) begin
                if (track_ok && track == saddr[g]) age <= age + 1;
                else                               age <= 1;
                track    <= saddr[g];
                track_ok <= 1'b1;
            end else begin
                track_ok <= 1'b0;
            end
        end

        assign sdi[g] = (!soe_n[g] && (AC == 1 || (track_ok && track == saddr[g] && age >= AC - 1)))
                        ? mem[saddr[g]] : 16'h0BAD;

        always @(negedge clk) begin
            if (rst) begin
                low_cnt = 0;
            end else if (!rdy[g]) begin
                low_cnt++;
            end else begin
                chk("idle_outputs", {swe_n[g], soe_n[g], soe[g], saddr[g], sdo[g]},
                    {1'b1, 1'b1, 1'b0, {ADDR_W{1'b0}}, 16'h0});
                if (low_cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: inst %0d completed with no pending access", g);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("ready_low_cycles", low_cnt, e.lat);
                        chk("mem_result", mres[g], e.res);
                        if (e.chk_mem) begin
                            chk("sram_lo_half", mem[e.a0], e.d0);
                            chk("sram_hi_half", mem[e.a0 + 1], e.d1);
                        end
                    end
                end
                low_cnt = 0;
            end
            if (!swe_n[g]) chk("write_ctrl", {soe[g], soe_n[g]}, 2'b11);
            if (!soe_n[g]) chk("read_ctrl", {soe[g], swe_n[g]}, 2'b01);
        end
    end

    task automatic wait_done(input int g);
        bit seen_low = 1'b0;
        bit ok       = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!rdy[g]) seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: inst %0d never returned ready", g);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic access(input int g, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int lat, input logic [31:0] res, input bit cm,
                          input logic [ADDR_W-1:0] a0, input logic [15:0] d0,
                          input logic [15:0] d1);
        exp_t e;
        e.lat = lat; e.res = res; e.chk_mem = cm; e.a0 = a0; e.d0 = d0; e.d1 = d1;
        exp_q.push_back(e);
        r_en[g] = r; w_en[g] = w; alu[g] = a; vrm[g] = d;
        wait_done(g);
        @(posedge clk); #1;
        r_en[g] = 1'b0; w_en[g] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 1'b0; w_en[i] = 1'b0; alu[i] = '0; vrm[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("idle_ready", rdy[i], 1'b1);
                chk("idle_ctrl", {swe_n[i], soe_n[i], soe[i]}, 3'b110);
                chk("idle_mem_result", mres[i], 32'h0);
            end
        end
        @(posedge clk); #1;

        access(0, 0, 1, BASE + 4, 32'hDEADBEEF, 5, 32'h0,        1, 18'd2, 16'hBEEF, 16'hDEAD);
        access(0, 1, 0, BASE + 4, 32'h0,        5, 32'hDEADBEEF, 0, 18'd0, 16'h0,    16'h0);
        access(0, 1, 0, BASE + 7, 32'h0,        5, 32'hDEADBEEF, 0, 18'd0, 16'h0,    16'h0);
        access(0, 1, 1, BASE,     32'h12345678, 5, 32'hDEADBEEF, 1, 18'd0, 16'h5678, 16'h1234);
        access(0, 1, 0, BASE,     32'h0,        5, 32'h12345678, 1, 18'd0, 16'h5678, 16'h1234);
        access(0, 0, 1, BASE - 4, 32'hCAFEF00D, 5, 32'h12345678, 1, 18'h3FFFE, 16'hF00D, 16'hCAFE);
        access(0, 1, 0, BASE - 4, 32'h0,        5, 32'hCAFEF00D, 0, 18'd0, 16'h0,    16'h0);

        // Reset lands during the second RD_LO cycle.
        r_en[0] = 1'b1; alu[0] = BASE + 4;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; r_en[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", rdy[0], 1'b1);
        chk("rst_oe_n", soe_n[0], 1'b1);
        chk("rst_mem_result", mres[0], 32'h0);
        @(posedge clk); #1;
        access(0, 1, 0, BASE + 4, 32'h0, 5, 32'hDEADBEEF, 0, 18'd0, 16'h0, 16'h0);

        access(1, 0, 1, BASE,     32'h11112222, 3, 32'h0,        1, 18'd0, 16'h2222, 16'h1111);
        access(1, 0, 1, BASE + 8, 32'h33334444, 3, 32'h0,        1, 18'd4, 16'h4444, 16'h3333);
        access(1, 1, 0, BASE,     32'h0,        3, 32'h11112222, 0, 18'd0, 16'h0,    16'h0);
        access(1, 1, 0, BASE + 8, 32'h0,        3, 32'h33334444, 0, 18'd0, 16'h0,    16'h0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
